// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: initiator FSM states and response codes.
package axil_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_A  = 3'd1,
        ST_RD_D  = 3'd2,
        ST_WR_AW = 3'd3,
        ST_WR_B  = 3'd4,
        ST_RESP  = 3'd5
    } axilm_state_e;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // True in the states that wait on the slave and therefore run the timeout.
    function automatic logic is_busy(input axilm_state_e s);
        return (s == ST_RD_A) || (s == ST_RD_D) || (s == ST_WR_AW) || (s == ST_WR_B);
    endfunction

endpackage

// File: rtl/axilite_master.sv
// AXI4-Lite initiator: turns one CPU load/store at a time into an AR/R or
// AW/W/B transaction, with a per-transaction timeout that reports a hung slave.
// Every AXI output is decoded from registered state only, so no AXI input
// reaches an output combinationally.
module axilite_master
    import axil_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  AXI_ACLK,
    input  logic                  AXI_ARESET,
    // CPU request / response
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_wstrb,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    // read address / data
    output logic [ADDR_W-1:0]     AXI_ARADDR,
    output logic                  AXI_ARVALID,
    input  logic                  AXI_ARREADY,
    input  logic [DATA_W-1:0]     AXI_RDATA,
    input  logic [1:0]            AXI_RRESP,
    input  logic                  AXI_RVALID,
    output logic                  AXI_RREADY,
    // write address / data / response
    output logic [ADDR_W-1:0]     AXI_AWADDR,
    output logic                  AXI_AWVALID,
    input  logic                  AXI_AWREADY,
    output logic [DATA_W-1:0]     AXI_WDATA,
    output logic [DATA_W/8-1:0]   AXI_WSTRB,
    output logic                  AXI_WVALID,
    input  logic                  AXI_WREADY,
    input  logic [1:0]            AXI_BRESP,
    input  logic                  AXI_BVALID,
    output logic                  AXI_BREADY
);

    localparam int              CNT_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

    axilm_state_e          state, state_nxt;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [DATA_W/8-1:0]   wstrb_q;
    logic [DATA_W-1:0]     rdata_q;
    logic                  err_q;
    logic                  aw_done, w_done;
    logic [CNT_W-1:0]      tmo_cnt;

    logic accept, busy, any_hs, tmo_abort;
    logic ar_hs, r_hs, aw_hs, w_hs, b_hs;

    assign accept = (state == ST_IDLE) && req_valid;
    assign busy   = is_busy(state);

    // Handshakes are qualified by state, which is exactly when the matching VALID/READY is high.
    assign ar_hs  = (state == ST_RD_A)  && AXI_ARREADY;
    assign r_hs   = (state == ST_RD_D)  && AXI_RVALID;
    assign aw_hs  = (state == ST_WR_AW) && !aw_done && AXI_AWREADY;
    assign w_hs   = (state == ST_WR_AW) && !w_done  && AXI_WREADY;
    assign b_hs   = (state == ST_WR_B)  && AXI_BVALID;
    assign any_hs = ar_hs || r_hs || aw_hs || w_hs || b_hs;

    // A handshake landing in the expiry cycle wins over the abort.
    assign tmo_abort = (TIMEOUT != 0) && busy && (tmo_cnt == CNT_LIMIT) && !any_hs;

    assign AXI_ARADDR = addr_q;
    assign AXI_AWADDR = addr_q;
    assign AXI_WDATA  = wdata_q;
    assign AXI_WSTRB  = wstrb_q;

    // State register.
    always_ff @(posedge AXI_ACLK) begin
        // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
        if (AXI_ARESET) state <= ST_IDLE;
        else            state <= state_nxt;
    end

    // Next-state decode: normal protocol progress first, timeout abort otherwise.
    always_comb begin
        // NOTE: default first so no path leaves state_nxt unassigned (that would infer a latch).
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (req_valid) state_nxt = req_we ? ST_WR_AW : ST_RD_A;
            ST_RD_A:  if (ar_hs) state_nxt = ST_RD_D;
                      else if (tmo_abort) state_nxt = ST_RESP;
            ST_RD_D:  if (r_hs || tmo_abort) state_nxt = ST_RESP;
            ST_WR_AW: if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = ST_WR_B;
                      else if (tmo_abort) state_nxt = ST_RESP;
            ST_WR_B:  if (b_hs || tmo_abort) state_nxt = ST_RESP;
            ST_RESP:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Output decode from registered state and done flags only.
    always_comb begin
        req_ready   = 1'b0;
        AXI_ARVALID = 1'b0;
        AXI_RREADY  = 1'b0;
        AXI_AWVALID = 1'b0;
        AXI_WVALID  = 1'b0;
        AXI_BREADY  = 1'b0;
        rsp_valid   = 1'b0;
        rsp_rdata   = '0;
        rsp_err     = 1'b0;
        unique case (state)
            ST_IDLE:  req_ready = !AXI_ARESET;
            ST_RD_A:  AXI_ARVALID = 1'b1;
            ST_RD_D:  AXI_RREADY = 1'b1;
            ST_WR_AW: begin
                AXI_AWVALID = !aw_done;
                AXI_WVALID  = !w_done;
            end
            ST_WR_B:  AXI_BREADY = 1'b1;
            ST_RESP: begin
                rsp_valid = 1'b1;
                rsp_rdata = rdata_q;
                rsp_err   = err_q;
            end
            default: ;
        endcase
    end

    // Request capture, channel done flags, response capture and the saturating timeout counter.
    always_ff @(posedge AXI_ACLK) begin
        if (AXI_ARESET) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            tmo_cnt <= '0;
        end else if (accept) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
            rdata_q <= '0;
            err_q   <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            tmo_cnt <= '0;
        end else begin
            if (busy && (tmo_cnt != CNT_LIMIT)) tmo_cnt <= tmo_cnt + 1'b1;
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
            if (r_hs) begin
                rdata_q <= AXI_RDATA;
                err_q   <= (AXI_RRESP != AXI_RESP_OKAY);
            end
            if (b_hs) begin
                rdata_q <= '0;
                err_q   <= (AXI_BRESP != AXI_RESP_OKAY);
            end
            if (tmo_abort) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axilite_master.sv
// Directed bench for axilite_master against a small in-bench memory slave.
// The slave registers its read data one cycle after the AR handshake, giving
// the four-cycle read latency of memslave; ready delays and response codes are
// configurable per test.
module tb_axilite_master;
    import axil_pkg::*;

    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic [31:0] axi_araddr;
    logic        axi_arvalid;
    logic        axi_arready = 1'b0;
    logic [31:0] axi_rdata = '0;
    logic [1:0]  axi_rresp = '0;
    logic        axi_rvalid = 1'b0;
    logic        axi_rready;
    logic [31:0] axi_awaddr;
    logic        axi_awvalid;
    logic        axi_awready = 1'b0;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_wvalid;
    logic        axi_wready = 1'b0;
    logic [1:0]  axi_bresp = '0;
    logic        axi_bvalid = 1'b0;
    logic        axi_bready;

    int errors = 0;
    int checks = 0;

    axilite_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
        .AXI_ACLK    (clk),
        .AXI_ARESET  (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_wstrb   (req_wstrb),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .AXI_ARADDR  (axi_araddr),
        .AXI_ARVALID (axi_arvalid),
        .AXI_ARREADY (axi_arready),
        .AXI_RDATA   (axi_rdata),
        .AXI_RRESP   (axi_rresp),
        .AXI_RVALID  (axi_rvalid),
        .AXI_RREADY  (axi_rready),
        .AXI_AWADDR  (axi_awaddr),
        .AXI_AWVALID (axi_awvalid),
        .AXI_AWREADY (axi_awready),
        .AXI_WDATA   (axi_wdata),
        .AXI_WSTRB   (axi_wstrb),
        .AXI_WVALID  (axi_wvalid),
        .AXI_WREADY  (axi_wready),
        .AXI_BRESP   (axi_bresp),
        .AXI_BVALID  (axi_bvalid),
        .AXI_BREADY  (axi_bready)
    );

    always #5 clk = ~clk;

    // ---------------- slave configuration and state ----------------
    logic        cfg_arready_en = 1'b1;
    int          cfg_r_lat = 0;
    int          cfg_aw_delay = 0;
    int          cfg_w_delay = 0;
    logic [1:0]  cfg_rresp = AXI_RESP_OKAY;
    logic [1:0]  cfg_bresp = AXI_RESP_OKAY;

    logic [31:0] mem [0:255];
    logic        rd_busy, aw_got, w_got;
    int          r_cnt, aw_cnt, w_cnt;
    logic [31:0] rd_addr, wr_addr, wr_data, slave_word;
    logic [3:0]  wr_strb;

    // Handshakes observed at each rising edge (pre-edge values), plus event counters.
    logic        s_ar_hs = 1'b0, s_r_hs = 1'b0, s_aw_hs = 1'b0, s_w_hs = 1'b0, s_b_hs = 1'b0;
    logic [31:0] s_ar_addr = '0, s_aw_addr = '0, s_w_data = '0;
    logic [3:0]  s_w_strb = '0;
    int ar_hs_n = 0, aw_hs_n = 0, w_hs_n = 0, bready_n = 0, rsp_n = 0;

    always @(posedge clk) begin
        s_ar_hs   <= axi_arvalid && axi_arready;
        s_r_hs    <= axi_rvalid && axi_rready;
        s_aw_hs   <= axi_awvalid && axi_awready;
        s_w_hs    <= axi_wvalid && axi_wready;
        s_b_hs    <= axi_bvalid && axi_bready;
        s_ar_addr <= axi_araddr;
        s_aw_addr <= axi_awaddr;
        s_w_data  <= axi_wdata;
        s_w_strb  <= axi_wstrb;
        if (!rst) begin
            ar_hs_n  <= ar_hs_n  + ((axi_arvalid && axi_arready) ? 1 : 0);
            aw_hs_n  <= aw_hs_n  + ((axi_awvalid && axi_awready) ? 1 : 0);
            w_hs_n   <= w_hs_n   + ((axi_wvalid && axi_wready) ? 1 : 0);
            bready_n <= bready_n + (axi_bready ? 1 : 0);
            rsp_n    <= rsp_n    + (rsp_valid ? 1 : 0);
        end
    end

    // Slave: reacts on the falling edge to handshakes taken at the preceding rising edge.
    initial begin : slave
        forever begin
            @(negedge clk);
            if (rst) begin
                axi_arready = 0; axi_rvalid = 0; axi_rdata = '0; axi_rresp = '0;
                axi_awready = 0; axi_wready = 0; axi_bvalid = 0; axi_bresp = '0;
                rd_busy = 0; aw_got = 0; w_got = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0;
                rd_addr = '0; wr_addr = '0; wr_data = '0; wr_strb = '0;
            end else begin
                // read channel
                if (s_r_hs) begin
                    axi_rvalid = 0; axi_rdata = '0; rd_busy = 0;
                end
                if (s_ar_hs) begin
                    rd_addr = s_ar_addr; rd_busy = 1; r_cnt = cfg_r_lat;
                end else if (rd_busy && !axi_rvalid) begin
                    if (r_cnt == 0) begin
                        axi_rvalid = 1; axi_rdata = mem[rd_addr[9:2]]; axi_rresp = cfg_rresp;
                    end else begin
                        r_cnt--;
                    end
                end
                axi_arready = cfg_arready_en && !rd_busy && axi_arvalid;
                // write channels
                if (s_b_hs) begin
                    axi_bvalid = 0; aw_got = 0; w_got = 0; aw_cnt = 0; w_cnt = 0;
                end
                if (s_aw_hs) begin
                    aw_got = 1; axi_awready = 0; wr_addr = s_aw_addr;
                end else if (axi_awvalid && !aw_got) begin
                    if (aw_cnt >= cfg_aw_delay) axi_awready = 1;
                    else aw_cnt++;
                end
                if (s_w_hs) begin
                    w_got = 1; axi_wready = 0; wr_data = s_w_data; wr_strb = s_w_strb;
                end else if (axi_wvalid && !w_got) begin
                    if (w_cnt >= cfg_w_delay) axi_wready = 1;
                    else w_cnt++;
                end
                if (aw_got && w_got && !axi_bvalid) begin
                    slave_word = mem[wr_addr[9:2]];
                    for (int i = 0; i < 4; i++)
                        if (wr_strb[i]) slave_word[8*i +: 8] = wr_data[8*i +: 8];
                    mem[wr_addr[9:2]] = slave_word;
                    axi_bvalid = 1; axi_bresp = cfg_bresp;
                end
            end
        end
    end

    // ---------------- helpers ----------------
    // Present one request at a falling edge; returns just after the accepting rising edge (cycle T).
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb);
        req_we = we; req_addr = addr; req_wdata = data; req_wstrb = strb; req_valid = 1'b1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready: req_ready=%b expected 1 (addr %h)", req_ready, addr);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Wait for rsp_valid, sampling at falling edges numbered first_k.. (cycle T+k); then confirm
    // the pulse is a single cycle and the master is idle again.
    task automatic wait_rsp(input int first_k, input int max_k, output int lat,
                            output logic [31:0] rd, output logic er);
        lat = 0; rd = '0; er = 1'b0;
        for (int k = first_k; k <= max_k; k++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                lat = k; rd = rsp_rdata; er = rsp_err;
                break;
            end
        end
        checks++;
        if (lat == 0) begin
            errors++;
            $display("FAIL rsp_wait: no rsp_valid by cycle T+%0d", max_k);
        end else begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
                errors++;
                $display("FAIL rsp_pulse: after rsp rsp_valid=%b req_ready=%b expected 0/1",
                         rsp_valid, req_ready);
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({req_ready, axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, axi_bready,
             rsp_valid, rsp_err} !== 8'b0 || rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outs: ready/valid bits=%b rsp_rdata=%h expected all 0",
                     {req_ready, axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, axi_bready,
                      rsp_valid, rsp_err}, rsp_rdata);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle_ready: req_ready=%b expected 1", req_ready);
        end
        checks++;
        if (axi_araddr !== 32'h0 || axi_wdata !== 32'h0 || axi_wstrb !== 4'h0 ||
            {axi_arvalid, axi_awvalid, axi_wvalid} !== 3'b0) begin
            errors++;
            $display("FAIL reset_regs: araddr=%h wdata=%h wstrb=%h valids=%b expected 0",
                     axi_araddr, axi_wdata, axi_wstrb, {axi_arvalid, axi_awvalid, axi_wvalid});
        end
    endtask

    task automatic test_read;
        int lat; logic [31:0] rd; logic er; int ar0;
        ar0 = ar_hs_n;
        issue(1'b0, 32'h10, 32'h0, 4'h0);
        wait_rsp(1, 20, lat, rd, er);
        checks++;
        if (lat != 4) begin
            errors++; $display("FAIL read_latency: rsp at T+%0d expected T+4", lat);
        end
        checks++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
            errors++; $display("FAIL read_data: rdata=%h err=%b expected deadbeef/0", rd, er);
        end
        checks++;
        if (ar_hs_n - ar0 != 1) begin
            errors++; $display("FAIL read_ar_count: %0d AR handshakes expected 1", ar_hs_n - ar0);
        end
    endtask

    task automatic test_write;
        int lat; logic [31:0] rd; logic er; int aw0, w0, b0;
        aw0 = aw_hs_n; w0 = w_hs_n; b0 = bready_n;
        issue(1'b1, 32'h20, 32'hCAFEF00D, 4'hF);
        wait_rsp(1, 20, lat, rd, er);
        checks++;
        if (lat != 3 || er !== 1'b0 || rd !== 32'h0) begin
            errors++;
            $display("FAIL write_rsp: lat=T+%0d err=%b rdata=%h expected T+3/0/0", lat, er, rd);
        end
        checks++;
        if (aw_hs_n - aw0 != 1 || w_hs_n - w0 != 1 || bready_n - b0 != 1) begin
            errors++;
            $display("FAIL write_hs: aw=%0d w=%0d bready_cycles=%0d expected 1/1/1",
                     aw_hs_n - aw0, w_hs_n - w0, bready_n - b0);
        end
    endtask

    // Read issued the cycle after the write's response cycle.
    task automatic test_back_to_back;
        int lat; logic [31:0] rd; logic er;
        issue(1'b0, 32'h20, 32'h0, 4'h0);
        wait_rsp(1, 20, lat, rd, er);
        checks++;
        if (lat != 4 || rd !== 32'hCAFEF00D || er !== 1'b0) begin
            errors++;
            $display("FAIL readback_20: lat=T+%0d rdata=%h err=%b expected T+4/cafef00d/0",
                     lat, rd, er);
        end
    endtask

    task automatic test_w_before_aw;
        int lat; logic [31:0] rd; logic er; int aw0, w0, r0;
        aw0 = aw_hs_n; w0 = w_hs_n; r0 = rsp_n;
        cfg_aw_delay = 3;
        issue(1'b1, 32'h24, 32'h11223344, 4'b0101);
        @(negedge clk);   // T+1
        checks++;
        if ({axi_awvalid, axi_wvalid} !== 2'b11 || axi_awaddr !== 32'h24 ||
            axi_wdata !== 32'h11223344 || axi_wstrb !== 4'b0101) begin
            errors++;
            $display("FAIL wr_issue: aw/w valid=%b awaddr=%h wdata=%h wstrb=%b expected 11/24/11223344/0101",
                     {axi_awvalid, axi_wvalid}, axi_awaddr, axi_wdata, axi_wstrb);
        end
        @(negedge clk);   // T+2
        checks++;
        if ({axi_awvalid, axi_wvalid} !== 2'b10) begin
            errors++;
            $display("FAIL w_drop: aw/w valid=%b expected 10", {axi_awvalid, axi_wvalid});
        end
        wait_rsp(3, 20, lat, rd, er);
        cfg_aw_delay = 0;
        checks++;
        if (lat != 6 || er !== 1'b0) begin
            errors++; $display("FAIL w_first_rsp: lat=T+%0d err=%b expected T+6/0", lat, er);
        end
        checks++;
        if (aw_hs_n - aw0 != 1 || w_hs_n - w0 != 1 || rsp_n - r0 != 1) begin
            errors++;
            $display("FAIL w_first_counts: aw=%0d w=%0d rsp=%0d expected 1/1/1",
                     aw_hs_n - aw0, w_hs_n - w0, rsp_n - r0);
        end
        issue(1'b0, 32'h24, 32'h0, 4'h0);
        wait_rsp(1, 20, lat, rd, er);
        checks++;
        if (rd !== 32'hAA22CC44 || er !== 1'b0) begin
            errors++; $display("FAIL strobe_merge: rdata=%h err=%b expected aa22cc44/0", rd, er);
        end
    endtask

    task automatic test_error_resp;
        int lat; logic [31:0] rd; logic er;
        cfg_bresp = AXI_RESP_SLVERR;
        issue(1'b1, 32'h28, 32'h00000055, 4'hF);
        wait_rsp(1, 20, lat, rd, er);
        cfg_bresp = AXI_RESP_OKAY;
        checks++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            errors++; $display("FAIL bresp_slverr: err=%b rdata=%h expected 1/0", er, rd);
        end
        cfg_rresp = AXI_RESP_DECERR;
        issue(1'b0, 32'h10, 32'h0, 4'h0);
        wait_rsp(1, 20, lat, rd, er);
        cfg_rresp = AXI_RESP_OKAY;
        checks++;
        if (er !== 1'b1 || rd !== 32'hDEADBEEF) begin
            errors++; $display("FAIL rresp_decerr: err=%b rdata=%h expected 1/deadbeef", er, rd);
        end
    endtask

    task automatic test_timeout;
        int lat; logic [31:0] rd; logic er;
        cfg_arready_en = 1'b0;
        issue(1'b0, 32'h10, 32'h0, 4'h0);
        repeat (TIMEOUT + 1) @(negedge clk);   // T+9: counter reaches TIMEOUT here
        checks++;
        if (axi_arvalid !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL tmo_hold: arvalid=%b rsp_valid=%b at T+9 expected 1/0",
                     axi_arvalid, rsp_valid);
        end
        @(negedge clk);                        // T+10
        checks++;
        if (axi_arvalid !== 1'b0 || rsp_valid !== 1'b1 || rsp_err !== 1'b1 ||
            rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL tmo_abort: arvalid=%b rsp_valid=%b err=%b rdata=%h expected 0/1/1/0",
                     axi_arvalid, rsp_valid, rsp_err, rsp_rdata);
        end
        cfg_arready_en = 1'b1;
        @(negedge clk);
        issue(1'b0, 32'h20, 32'h0, 4'h0);
        wait_rsp(1, 20, lat, rd, er);
        checks++;
        if (lat != 4 || rd !== 32'hCAFEF00D || er !== 1'b0) begin
            errors++;
            $display("FAIL tmo_recover: lat=T+%0d rdata=%h err=%b expected T+4/cafef00d/0",
                     lat, rd, er);
        end
    endtask

    task automatic test_reset_mid;
        int lat; logic [31:0] rd; logic er; int r0; logic found;
        r0 = rsp_n;
        cfg_r_lat = 5;
        issue(1'b0, 32'h10, 32'h0, 4'h0);
        found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (axi_rready === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL mid_rd_d: rready=%b never reached RD_D", axi_rready);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({req_ready, axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, axi_bready,
             rsp_valid, rsp_err} !== 8'b0 || rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset_outs: bits=%b rdata=%h expected all 0",
                     {req_ready, axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, axi_bready,
                      rsp_valid, rsp_err}, rsp_rdata);
        end
        @(negedge clk);
        rst = 1'b0;
        cfg_r_lat = 0;
        repeat (4) @(negedge clk);
        checks++;
        if (rsp_n != r0) begin
            errors++; $display("FAIL mid_no_rsp: %0d responses expected 0", rsp_n - r0);
        end
        issue(1'b0, 32'h20, 32'h0, 4'h0);
        wait_rsp(1, 20, lat, rd, er);
        checks++;
        if (lat != 4 || rd !== 32'hCAFEF00D || er !== 1'b0) begin
            errors++;
            $display("FAIL mid_fresh_read: lat=T+%0d rdata=%h err=%b expected T+4/cafef00d/0",
                     lat, rd, er);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[32'h10 >> 2] = 32'hDEADBEEF;
        mem[32'h24 >> 2] = 32'hAABBCCDD;
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_w_before_aw();
        test_error_resp();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
